// File: rtl/nibble_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// nsa_pkg
// Shared definitions for nibble_serial_adder: FSM state encoding and the
// width of the reused adder slice.
// No ports (package).
// -----------------------------------------------------------------------------
package nsa_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } nsa_state_t;

endpackage : nsa_pkg

// File: rtl/carry_select_adder.sv
// -----------------------------------------------------------------------------
// carry_select_adder
// 4-bit carry-select adder slice. Both carry-in outcomes are computed in
// parallel and the real carry-in only picks between them.
// Ports:
//   i_a, i_b  [3:0] operands
//   i_cin           carry in
//   o_sum     [3:0] sum
//   o_cout          carry out
// -----------------------------------------------------------------------------
module carry_select_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [4:0] w_sum_c0;
    logic [4:0] w_sum_c1;

    assign w_sum_c0 = {1'b0, i_a} + {1'b0, i_b};
    assign w_sum_c1 = w_sum_c0 + 5'd1;

    assign {o_cout, o_sum} = i_cin ? w_sum_c1 : w_sum_c0;

endmodule : carry_select_adder

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// Adds two WIDTH-bit operands one nibble per clock using a single 4-bit
// carry_select_adder slice. The inter-nibble carry is registered.
// Optional macro NSA_OVERFLOW_EN adds the 'ovf' output (two's-complement
// signed overflow, registered with cout).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b, cin)
//   a, b      [WIDTH-1:0] operands
//   cin                   carry into nibble 0
//   out_valid / out_ready result handshake (sum, cout)
//   sum       [WIDTH-1:0] result
//   cout                  carry out of MSB nibble
//   busy                  high while in RUN or DONE
//   ovf                   signed overflow (NSA_OVERFLOW_EN only)
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; the producer holds its data stable until then, and ready never
// depends combinationally on valid.
// -----------------------------------------------------------------------------
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef NSA_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NIB   = WIDTH / SLICE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    nsa_state_t       r_state;
    nsa_state_t       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_slice_sum;
    logic             w_slice_cout;
    logic             w_last;

    assign w_a_nib = r_a[SLICE_W*int'(r_cnt) +: SLICE_W];
    assign w_b_nib = r_b[SLICE_W*int'(r_cnt) +: SLICE_W];
    assign w_last  = (r_cnt == CNT_W'(NIB - 1));

    carry_select_adder u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture and nibble-by-nibble accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[SLICE_W*int'(r_cnt) +: SLICE_W] <= w_slice_sum;
                    r_carry <= w_slice_cout;
                    if (w_last) begin
                        r_cout <= w_slice_cout;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef NSA_OVERFLOW_EN
    logic r_ovf;

    // Signed overflow: operands agree in sign but the result's sign differs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                     (w_slice_sum[3] != r_a[WIDTH-1]);
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
// Self-checking bench for nibble_serial_adder (WIDTH=16). Expected results come
// from plain integer addition of the accepted operands. Define NSA_OVERFLOW_EN
// for both files to also check the ovf output.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef NSA_OVERFLOW_EN
    logic         ovf;
    logic         exp_ovf_q[$];
`endif

    logic [W:0]   exp_q[$];
    int           n_checks;
    int           n_errors;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef NSA_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the true (W+1)-bit sum of the accepted operands.
    task automatic model_push(input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic tcin);
        logic [W:0] full;
        full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tcin};
        exp_q.push_back(full);
`ifdef NSA_OVERFLOW_EN
        exp_ovf_q.push_back((ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]));
`endif
    endtask

    // One full transaction. hold = cycles of out_ready=0 while in DONE
    // (0 means out_ready tied high). noise = drive other operands with
    // in_valid high while the block is busy.
    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tcin, input int hold, input bit noise);
        int         lat;
        logic [W:0] exp;
        logic [W:0] got;
        model_push(ta, tb, tcin);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        a         = ta;
        b         = tb;
        cin       = tcin;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        if (noise) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom_range(0, 1));
        end else begin
            in_valid = 1'b0;
        end
        check("run_in_ready", {31'd0, in_ready}, 32'd0);
        check("run_busy", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, NIB + 1);
        exp = exp_q.pop_front();
        got = {cout, sum};
        check("result", {15'd0, got}, {15'd0, exp});
`ifdef NSA_OVERFLOW_EN
        check("ovf", {31'd0, ovf}, {31'd0, exp_ovf_q.pop_front()});
`endif
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_result", {15'd0, cout, sum}, {15'd0, exp});
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset state
        #12;
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_txn(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        run_txn(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_txn(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
        run_txn(16'h00F0, 16'h0010, 1'b0, 6, 1'b0);
        run_txn(16'h0F0F, 16'h0101, 1'b1, 1, 1'b1);
        run_txn(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run_txn(16'h8000, 16'hFFFF, 1'b0, 0, 1'b0);
        run_txn(16'h0003, 16'h0004, 1'b0, 0, 1'b0);

        // Reset in the middle of RUN
        a        = 16'hABCD;
        b        = 16'h1357;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_sum", {16'd0, sum}, 32'd0);
        check("mid_rst_cout", {31'd0, cout}, 32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_txn(16'h8000, 16'h8000, 1'b0, 0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            run_txn(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_nibble_serial_adder

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequential wrapper that adds two WIDTH-bit operands four bits per clock by reusing one 4-bit carry-select adder slice.
- Captures a/b/cin through a valid/ready input handshake and feeds successive nibbles to the slice, registering the inter-nibble carry.
- Presents the full sum and carry-out through a valid/ready output handshake.
- Sits directly upstream of the 4-bit carry_select_adder, acting as its operand sequencer.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and >= 4.
- NIB, WIDTH/4, number of nibble slices (derived localparam, not overridable).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present on a/b/cin.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of MSB nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, any state): state=IDLE, sum=0, cout=0, out_valid=0, busy=0, in_ready=1, cnt=0, carry=0, operand registers=0. Any in-flight transaction is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b; carry<=cin; cnt<=0; sum<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: slice input = a_reg[4*cnt+:4], b_reg[4*cnt+:4], carry.
  - Write slice sum into sum[4*cnt+:4]; carry<=slice cout; cnt<=cnt+1.
  - When cnt==NIB-1: cout<=slice cout; go to DONE. cnt does not wrap past NIB-1.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready: out_valid<=0; go to IDLE.
  - in_ready=0 in DONE; no same-cycle re-accept.
- Latency: handshake on cycle T, out_valid high from cycle T+NIB+1. Throughput: one result per NIB+2 cycles when out_ready is tied high.
- in_valid while not in IDLE is ignored; the upstream source must hold its data.
- out_ready while not in DONE is ignored.
- WIDTH=4: exactly one RUN cycle.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true carry-out.
- Elaboration fails (generate-time $error / invalid instance) if WIDTH%4!=0.

Optional Feature:
- Macro: NSA_OVERFLOW_EN.
- Defined:
  - Adds output port ovf (1 bit), registered in the same last RUN cycle as cout.
  - ovf = (a_reg[MSB]==b_reg[MSB]) && (slice sum[3]!=a_reg[MSB]), i.e. two's-complement signed overflow.
  - ovf reset value is 0; held through DONE.
- Undefined: no ovf port and no associated logic.

Decomposition:
- Package nsa_pkg holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - SLICE_W=4.
- Sub-module: one instance of the existing carry_select_adder for the per-cycle 4-bit add. It is reused unchanged; no new sub-module is required.
- Counter width: $clog2(NIB), minimum 1.

Test Plan:
- Basic add, WIDTH=16, out_ready=1: a=16'h1234, b=16'h4321, cin=0 -> sum=16'h5555, cout=0; out_valid rises exactly 5 cycles after the accept edge.
- Full ripple: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1. Then a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
- Backpressure: complete a=16'h00F0 + b=16'h0010, hold out_ready=0 for 6 cycles -> sum=16'h0100, cout=0 stable, in_ready=0. Raise out_ready -> in_ready=1 next cycle.
- Ignored input: toggle in_valid with new data during RUN -> result still matches the originally accepted operands; the new data is accepted only once back in IDLE.
- Reset mid-RUN: assert rst after 2 RUN cycles -> sum, cout, out_valid=0 and in_ready=1 immediately (async). Next transaction a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1.
- NSA_OVERFLOW_EN defined:
  - 16'h7FFF+16'h0001 -> sum=16'h8000, ovf=1.
  - 16'h8000+16'hFFFF -> sum=16'h7FFF, cout=1, ovf=1.
  - 16'h0003+16'h0004 -> ovf=0.
